// File: rtl/pe_feeder_if.sv
// Sample stream in, frame bundle out to the butterfly PE.
interface pe_feeder_if #(
    parameter int WIDTH = 32
);
    logic               s_valid;
    logic [2*WIDTH-1:0] s_data;
    logic               s_ready;
    logic [2*WIDTH-1:0] pe_in0;
    logic [2*WIDTH-1:0] pe_in1;
    logic [2*WIDTH-1:0] pe_in2;
    logic [2*WIDTH-1:0] pe_in3;
    logic [2*WIDTH-1:0] pe_tf;
    logic               pe_bypass_n;
    logic               pe_valid;
    logic               res_valid;

    modport slave (
        input  s_valid, s_data,
        output s_ready, pe_in0, pe_in1, pe_in2, pe_in3,
        output pe_tf, pe_bypass_n, pe_valid, res_valid
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, pe_in0, pe_in1, pe_in2, pe_in3,
        input  pe_tf, pe_bypass_n, pe_valid, res_valid
    );
endinterface

// File: rtl/pe_feeder.sv
// Groups 4 complex samples into a frame and presents it with a twiddle word.
module pe_feeder #(
    parameter int WIDTH = 32,
    parameter int TFAW  = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               tf_wr_en,
    input  logic [TFAW-1:0]    tf_wr_addr,
    input  logic [2*WIDTH-1:0] tf_wr_data,
    input  logic               bypass_n_cfg,
    output logic               busy,
    pe_feeder_if.slave         bus
);
    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         slot_cnt;
    logic [TFAW-1:0]    tf_idx;
    logic [2*WIDTH-1:0] tab [2**TFAW];
    logic [2*WIDTH-1:0] slot [3];
    logic [2:0]         dly;
    logic               acc;
    logic               fire;

    assign bus.s_ready   = (state != LOAD);
    assign busy          = (state != LOAD);
    assign acc           = bus.s_valid && bus.s_ready;
    assign fire          = acc && (slot_cnt == 2'd3);
    assign bus.res_valid = dly[2];

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = (slot_cnt == 2'd0) ? LOAD : DRAIN;
            DRAIN:   if (fire) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= LOAD;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            slot_cnt <= '0;
            tf_idx   <= '0;
        end else if (state == LOAD) begin
            if (start) begin
                slot_cnt <= '0;
                tf_idx   <= '0;
            end
        end else if (acc) begin
            slot_cnt <= slot_cnt + 2'd1;
            if (fire) tf_idx <= tf_idx + 1'b1;
        end
    end

    // Slot 3 goes straight to the present registers, so only 0..2 are held.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 3; i++) slot[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (acc && slot_cnt == 2'(i)) slot[i] <= bus.s_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.pe_in0      <= '0;
            bus.pe_in1      <= '0;
            bus.pe_in2      <= '0;
            bus.pe_in3      <= '0;
            bus.pe_tf       <= '0;
            bus.pe_bypass_n <= 1'b0;
            bus.pe_valid    <= 1'b0;
            dly             <= '0;
        end else begin
            bus.pe_valid <= fire;
            dly          <= {dly[1:0], bus.pe_valid};
            if (fire) begin
                bus.pe_in0      <= slot[0];
                bus.pe_in1      <= slot[1];
                bus.pe_in2      <= slot[2];
                bus.pe_in3      <= bus.s_data;
                bus.pe_tf       <= tab[tf_idx];
                bus.pe_bypass_n <= bypass_n_cfg;
            end
        end
    end

    // Table survives reset; writable only while idle.
    always_ff @(posedge Clk) begin
        if (state == LOAD && tf_wr_en) tab[tf_wr_addr] <= tf_wr_data;
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Directed stimulus with a frame scoreboard checked by a separate monitor.
module tb_pe_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tf_wr_en = 1'b0;
    logic [3:0]  tf_wr_addr = '0;
    logic [63:0] tf_wr_data = '0;
    logic        bypass_n_cfg = 1'b1;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] in0, in1, in2, in3, tf;
        logic        byp;
        int          cyc;
    } frame_t;

    frame_t      expq[$];
    logic [63:0] tab_m [16];
    logic [63:0] m_buf [4];
    int          m_n = 0;
    logic [3:0]  m_idx = '0;
    logic [2:0]  pv_h = '0;

    pe_feeder_if #(.WIDTH(32)) bus ();

    pe_feeder #(.WIDTH(32), .TFAW(4)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .start        (start),
        .stop         (stop),
        .tf_wr_en     (tf_wr_en),
        .tf_wr_addr   (tf_wr_addr),
        .tf_wr_data   (tf_wr_data),
        .bypass_n_cfg (bypass_n_cfg),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tf(input logic [3:0] a, input logic [63:0] d);
        tf_wr_en = 1'b1;
        tf_wr_addr = a;
        tf_wr_data = d;
        tick();
        tf_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_idx = '0;
        m_n = 0;
    endtask

    task automatic send(input logic [63:0] d);
        frame_t e;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        tick();
        bus.s_valid = 1'b0;
        m_buf[m_n] = d;
        m_n++;
        if (m_n == 4) begin
            e.in0 = m_buf[0];
            e.in1 = m_buf[1];
            e.in2 = m_buf[2];
            e.in3 = m_buf[3];
            e.tf  = tab_m[m_idx];
            e.byp = bypass_n_cfg;
            e.cyc = cyc;
            expq.push_back(e);
            m_idx = m_idx + 4'd1;
            m_n = 0;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pe_in0"}, bus.pe_in0, 64'd0);
        chk({tag, "_pe_in1"}, bus.pe_in1, 64'd0);
        chk({tag, "_pe_in2"}, bus.pe_in2, 64'd0);
        chk({tag, "_pe_in3"}, bus.pe_in3, 64'd0);
        chk({tag, "_pe_tf"}, bus.pe_tf, 64'd0);
        chk({tag, "_pe_byp"}, 64'(bus.pe_bypass_n), 64'd0);
        chk({tag, "_pe_valid"}, 64'(bus.pe_valid), 64'd0);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        frame_t e;
        if (!rst_n) begin
            pv_h = '0;
        end else begin
            if (bus.res_valid || pv_h[2])
                chk("res_valid_delay", 64'(bus.res_valid), 64'(pv_h[2]));
            pv_h = {pv_h[1:0], bus.pe_valid};
            if (bus.pe_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_pe_valid: got 1 want 0 at cyc %0d", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("frame_cycle", 64'(cyc), 64'(e.cyc));
                    chk("pe_in0", bus.pe_in0, e.in0);
                    chk("pe_in1", bus.pe_in1, e.in1);
                    chk("pe_in2", bus.pe_in2, e.in2);
                    chk("pe_in3", bus.pe_in3, e.in3);
                    chk("pe_tf", bus.pe_tf, e.tf);
                    chk("pe_bypass_n", 64'(bus.pe_bypass_n), 64'(e.byp));
                end
            end
        end
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        tab_m[0] = 64'h0001_0000_0000_0000;
        tab_m[1] = 64'h0000_0000_0001_0000;
        for (int i = 2; i < 16; i++)
            tab_m[i] = {32'h0000_0100 + 32'(i), 32'h0000_0200 + 32'(i)};

        tick();
        tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) wr_tf(4'(i), tab_m[i]);

        pulse_start();
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_s_ready", 64'(bus.s_ready), 64'd1);
        send(64'd1);
        send(64'd2);
        send(64'd3);
        send(64'd4);
        repeat (5) tick();
        chk("hold_pe_in0", bus.pe_in0, 64'd1);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_idle_busy", 64'(busy), 64'd0);
        pulse_start();
        for (int i = 0; i < 68; i++) send(64'h1000 + 64'(i));
        repeat (5) tick();

        wr_tf(4'd2, 64'hDEAD_BEEF_DEAD_BEEF);
        bypass_n_cfg = 1'b0;
        for (int i = 0; i < 4; i++) send(64'h2000 + 64'(i));
        bypass_n_cfg = 1'b1;
        for (int i = 0; i < 4; i++) send(64'h3000 + 64'(i));
        repeat (5) tick();

        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("both_in_run_busy", 64'(busy), 64'd0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        m_idx = '0;
        m_n = 0;
        chk("both_in_load_busy", 64'(busy), 64'd1);

        send(64'hA1);
        send(64'hA2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) begin
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_s_ready", 64'(bus.s_ready), 64'd1);
            tick();
        end
        send(64'hA3);
        send(64'hA4);
        chk("drain_done_busy", 64'(busy), 64'd0);
        chk("drain_done_s_ready", 64'(bus.s_ready), 64'd0);
        repeat (5) tick();

        pulse_start();
        send(64'hB1);
        send(64'hB2);
        send(64'hB3);
        rst_n = 1'b0;
        tick();
        chk_zero_outputs("midreset");
        rst_n = 1'b1;
        m_n = 0;
        tick();
        pulse_start();
        send(64'hC1);
        send(64'hC2);
        send(64'hC3);
        send(64'hC4);
        repeat (6) tick();

        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
